scrambler_multilane: RTL and testbench
======================================

// Module: scrambler_multilane
// PURPOSE
//  Parametrised multi-lane self-synchronous scrambler/descrambler, polynomial 1 + x^POLY_LO + x^POLY_HI.
//  - 64b/66b default: x^58 + x^39 + 1.
//  - One instance scrambles (MODE=0) or descrambles (MODE=1) LANES independent payload lanes.
//  - Adds per-lane enable, seed load and lock (history-flushed) status.
//  - Sits between encoder/TPG and SerDes gearbox on TX; mirrored on RX.
// PARAMETERS
//  DATA_W   64  payload bits per lane per word (>=1)
//  LANES    4   number of independent lanes (>=1)
//  POLY_HI  58  high tap; also the per-lane history depth in bits
//  POLY_LO  39  low tap; 1 <= POLY_LO < POLY_HI
//  MODE     0   0 = scramble, 1 = descramble
// PORTS
//  CLK          in   1              rising-edge clock
//  reset_n      in   1              asynchronous, active-low reset
//  in_valid     in   1              in_data holds a word this cycle
//  in_data      in   LANES*DATA_W   lane L at [L*DATA_W +: DATA_W]; bit 0 is first in time
//  lane_en      in   LANES          per-lane enable
//  seed_load    in   1              load seed_value into every enabled lane's history
//  seed_value   in   POLY_HI        history image; bit j = stream bit j+1 positions back
//  out_valid    out  1              out_data valid
//  out_data     out  LANES*DATA_W   processed data, same lane/bit layout as in_data
//  lane_locked  out  LANES          lane history is fully defined by the stream or the seed
// BEHAVIOUR
//  - Per-lane history H[POLY_HI-1:0]; H[0] is the most recent stream bit.
//    - h(j) is the stream bit j positions earlier. It is taken from earlier bits of the same word, else from H.
//  - For word bit k (k=0..DATA_W-1): y_k = x_k ^ h(POLY_LO) ^ h(POLY_HI).
//    - MODE=0: the history stream is y (the scrambled output).
//    - MODE=1: the history stream is x (the received input).
//  - Output is registered; latency is 1 cycle.
//    - out_valid = in_valid delayed 1 cycle. There is no backpressure.
//  - Reset: out_valid=0, out_data=0, lane_locked=0, all H=0, all lock counters=0.
//    - Reset asserted mid-word discards that word; no output for it.
//  - H and lock counter update only on in_valid=1 with lane_en[L]=1.
//  - lane_en[L]=0:
//    - lane L out_data slice is 0 on the next valid output.
//    - H is held.
//    - lock counter and lane_locked are cleared.
//  - Lock counter, per lane:
//    - Counts consumed stream bits and saturates at POLY_HI.
//    - Width is $clog2(POLY_HI+1).
//    - lane_locked=1 while the count equals POLY_HI.
//    - It is registered with out_data: it rises in the same cycle out_valid presents the word whose bits complete POLY_HI.
//    - DATA_W >= POLY_HI: lane_locked rises with the first valid output after reset.
//  - seed_load=1:
//    - For enabled lanes, H <= seed_value and the lock counter is forced to POLY_HI (lane_locked=1 next cycle).
//    - seed_load with in_valid in the same cycle: seed_value is used as the history for that word.
//      The resulting post-word history is what is stored.
//    - seed_load takes priority over lane_en=0 clearing only for enabled lanes; disabled lanes ignore the seed.
//  - in_valid=0: no state changes; out_data holds its last value; out_valid=0.
// CONFIGURATION
//  SCR_BYPASS_EN defined:
//  - Adds input port `bypass` (1 bit).
//  - bypass=1: out_data = in_data & lane mask, 1-cycle latency.
//  - bypass=1: H and lock counters are frozen; seed_load is still honoured.
//  SCR_BYPASS_EN undefined:
//  - No bypass port; behaviour is identical to bypass=0.
// TESTING
//  1. MODE=0, LANES=1, all-zero input, 8 valid words after reset -> out_data=0 for every word, out_valid 1 cycle after in_valid.
//  2. MODE=0, first word 64'h1, then zeros -> first output 64'h0400_0080_0000_0001; lane_locked=1 on that same output.
//  3. Scrambler(MODE=0) -> descrambler(MODE=1), LANES=4, lanes carry {4{16-bit counter}}:
//     - The descrambler output equals the scrambler input delayed 2 cycles from the second word on.
//     - lane_locked=4'hF from the first descrambler output.
//  4. lane_en=4'b1011 for 3 words mid-stream:
//     - lane 2 output is 0 for those words and lane_locked[2] drops.
//     - After re-enable, lane 2 is locked again after 1 word (DATA_W=64).
//     - Lanes 0, 1 and 3 are unaffected.
//  5. seed_load with seed_value=58'h3FF_FFFF_FFFF_FFFF together with in_valid and zero data:
//     - The output matches a golden model seeded identically.
//     - lane_locked=1 on the next cycle.
//  6. reset_n pulsed low for 3 ns mid-stream:
//     - Outputs, out_valid and lane_locked go 0 immediately (asynchronously).
//     - After release, behaviour matches test 1 from a clean start.
//     - With SCR_BYPASS_EN and bypass=1: out_data == in_data delayed 1 cycle.

Source files
------------

// File: rtl/scrambler_multilane.sv
// scrambler_multilane: LANES independent self-synchronous scramblers
// (MODE=0) or descramblers (MODE=1) for polynomial 1 + x^POLY_LO + x^POLY_HI.
// Each lane keeps a POLY_HI-bit history and a saturating lock counter.
// Output is registered with 1-cycle latency. There is no backpressure.
// Optional feature macro: SCR_BYPASS_EN adds a `bypass` input. When bypass
// is high, data passes through with the lane mask applied and history and
// lock state are frozen.
module scrambler_multilane #(
   parameter int DATA_W  = 64,
   parameter int LANES   = 4,
   parameter int POLY_HI = 58,
   parameter int POLY_LO = 39,
   parameter int MODE    = 0
) (
   input  logic                      CLK,
   input  logic                      reset_n,
`ifdef SCR_BYPASS_EN
   input  logic                      bypass,
`endif
   input  logic                      in_valid,
   input  logic [LANES*DATA_W-1:0]   in_data,
   input  logic [LANES-1:0]          lane_en,
   input  logic                      seed_load,
   input  logic [POLY_HI-1:0]        seed_value,
   output logic                      out_valid,
   output logic [LANES*DATA_W-1:0]   out_data,
   output logic [LANES-1:0]          lane_locked
);

   localparam int CNT_W = $clog2(POLY_HI + 1);
   localparam int EXT_W = POLY_HI + DATA_W;
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(POLY_HI);

   logic byp;
`ifdef SCR_BYPASS_EN
   assign byp = bypass;
`else
   assign byp = 1'b0;
`endif

   // Process one lane word against a starting history.
   // The result is {post-word history, processed word}.
   // s[] is the stream laid out oldest-first: s[POLY_HI-1] is the most recent
   // history bit, and s[POLY_HI+k] is word bit k. Tap j for bit k is therefore
   // s[POLY_HI+k-j].
   function automatic logic [EXT_W-1:0] scr_word(input logic [DATA_W-1:0]  x,
                                                 input logic [POLY_HI-1:0] hist);
      logic [EXT_W-1:0]   s;
      logic [DATA_W-1:0]  y;
      logic [POLY_HI-1:0] h_new;
      s = '0;
      y = '0;
      for (int j = 0; j < POLY_HI; j++) s[POLY_HI-1-j] = hist[j];
      for (int k = 0; k < DATA_W; k++) begin
         y[k] = x[k] ^ s[POLY_HI+k-POLY_LO] ^ s[k];
         s[POLY_HI+k] = (MODE == 0) ? y[k] : x[k];
      end
      for (int j = 0; j < POLY_HI; j++) h_new[j] = s[EXT_W-1-j];
      return {h_new, y};
   endfunction

   // Add one word's worth of bits to the lock counter, saturating at POLY_HI.
   function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] c);
      int n;
      n = int'(c) + DATA_W;
      if (n > POLY_HI) n = POLY_HI;
      return CNT_W'(n);
   endfunction

   logic [POLY_HI-1:0]       hist_q [LANES];
   logic [POLY_HI-1:0]       hist_d [LANES];
   logic [CNT_W-1:0]         cnt_q  [LANES];
   logic [CNT_W-1:0]         cnt_d  [LANES];
   logic [LANES*DATA_W-1:0]  data_d;
   logic [LANES-1:0]         lock_d;
   logic [LANES*DATA_W-1:0]  data_p1;
   logic [LANES-1:0]         lock_p1;
   logic                     vld_p1;
   logic [EXT_W-1:0]         res;
   logic                     seed_en;

   // Per-lane next-state: processed word, new history, lock counter.
   always_comb begin
      data_d  = data_p1;
      lock_d  = '0;
      res     = '0;
      seed_en = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         hist_d[l] = hist_q[l];
         cnt_d[l]  = cnt_q[l];
         seed_en   = seed_load && lane_en[l];
         // A seed loaded alongside a word becomes that word's history.
         res = scr_word(in_data[l*DATA_W +: DATA_W],
                        seed_en ? seed_value : hist_q[l]);
         if (in_valid) begin
            if (byp) begin
               data_d[l*DATA_W +: DATA_W] = lane_en[l] ? in_data[l*DATA_W +: DATA_W] : '0;
            end else if (lane_en[l]) begin
               data_d[l*DATA_W +: DATA_W] = res[DATA_W-1:0];
               hist_d[l] = res[EXT_W-1:DATA_W];
               cnt_d[l]  = seed_en ? CNT_FULL : sat_cnt(cnt_q[l]);
            end else begin
               data_d[l*DATA_W +: DATA_W] = '0;
               cnt_d[l] = '0;
            end
         end
         // A seed loaded with no word processed is stored as-is.
         if (seed_en && !(in_valid && !byp)) begin
            hist_d[l] = seed_value;
            cnt_d[l]  = CNT_FULL;
         end
         lock_d[l] = (cnt_d[l] == CNT_FULL);
      end
   end

   // Output stage and lane state registers.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         vld_p1  <= 1'b0;
         data_p1 <= '0;
         lock_p1 <= '0;
         hist_q  <= '{default: '0};
         cnt_q   <= '{default: '0};
      end else begin
         vld_p1  <= in_valid;
         data_p1 <= data_d;
         lock_p1 <= lock_d;
         hist_q  <= hist_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid   = vld_p1;
   assign out_data    = data_p1;
   assign lane_locked = lock_p1;

endmodule

// File: tb/tb_scrambler_multilane.sv
// Bench for scrambler_multilane. It chains a scrambler into a descrambler and
// checks both against a bit-serial stream model on every cycle. Directed
// literal checks pin the model's expected values.
module tb_scrambler_multilane;
   localparam int DW = 64;
   localparam int NL = 4;
   localparam int PH = 58;
   localparam int PL = 39;
   localparam int TW = NL * DW;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic           reset_n;
   logic           in_valid;
   logic [TW-1:0]  in_data;
   logic [NL-1:0]  lane_en;
   logic           seed_load;
   logic [PH-1:0]  seed_value;
   logic           s_vld, d_vld;
   logic [TW-1:0]  s_data, d_data;
   logic [NL-1:0]  s_lock, d_lock;
   logic [NL-1:0]  all_en    = '1;
   logic           no_seed   = 1'b0;
   logic [PH-1:0]  zero_seed = '0;
`ifdef SCR_BYPASS_EN
   logic           bypass    = 1'b0;
`endif

   scrambler_multilane #(.DATA_W(DW), .LANES(NL), .POLY_HI(PH), .POLY_LO(PL), .MODE(0)) u_scr (
      .CLK(CLK), .reset_n(reset_n),
`ifdef SCR_BYPASS_EN
      .bypass(bypass),
`endif
      .in_valid(in_valid), .in_data(in_data), .lane_en(lane_en),
      .seed_load(seed_load), .seed_value(seed_value),
      .out_valid(s_vld), .out_data(s_data), .lane_locked(s_lock));

   scrambler_multilane #(.DATA_W(DW), .LANES(NL), .POLY_HI(PH), .POLY_LO(PL), .MODE(1)) u_dsc (
      .CLK(CLK), .reset_n(reset_n),
`ifdef SCR_BYPASS_EN
      .bypass(bypass),
`endif
      .in_valid(s_vld), .in_data(s_data), .lane_en(all_en),
      .seed_load(no_seed), .seed_value(zero_seed),
      .out_valid(d_vld), .out_data(d_data), .lane_locked(d_lock));

   // ---------------- model: index 0 = scrambler, 1 = descrambler ----------------
   logic [PH-1:0] mh [2][NL];
   int            mcnt [2][NL];
   logic          e_vld [2];
   logic [TW-1:0] e_data [2];
   logic [NL-1:0] e_lock [2];

   int   n_cmp = 0;
   int   n_bad = 0;
   logic chk_on = 1'b0;

   task automatic chk(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         e_vld[i]  = 1'b0;
         e_data[i] = '0;
         e_lock[i] = '0;
         for (int l = 0; l < NL; l++) begin
            mh[i][l]   = '0;
            mcnt[i][l] = 0;
         end
      end
   endtask

   // Bit-serial reference: the stream is a queue, oldest first, and tap j is
   // the bit j places back from the end of the queue.
   function automatic void run_word(input int mode, input logic [DW-1:0] x, input logic [PH-1:0] hin,
                                    output logic [DW-1:0] y, output logic [PH-1:0] hout);
      bit s[$];
      int t;
      bit yb;
      s = {};
      for (int j = PH - 1; j >= 0; j--) s.push_back(hin[j]);
      y = '0;
      for (int k = 0; k < DW; k++) begin
         t  = s.size();
         yb = x[k] ^ s[t-PL] ^ s[t-PH];
         y[k] = yb;
         s.push_back(mode != 0 ? x[k] : yb);
      end
      t = s.size();
      hout = '0;
      for (int j = 0; j < PH; j++) hout[j] = s[t-1-j];
   endfunction

   task automatic model_step(input int i, input logic v, input logic [TW-1:0] x, input logic [NL-1:0] en,
                             input logic sl, input logic [PH-1:0] sv);
      logic [DW-1:0] y;
      logic [PH-1:0] hn;
      e_vld[i] = v;
      for (int l = 0; l < NL; l++) begin
         if (v) begin
            if (en[l]) begin
               run_word(i, x[l*DW +: DW], sl ? sv : mh[i][l], y, hn);
               e_data[i][l*DW +: DW] = y;
               mh[i][l]   = hn;
               mcnt[i][l] = sl ? PH : ((mcnt[i][l] + DW > PH) ? PH : mcnt[i][l] + DW);
            end else begin
               e_data[i][l*DW +: DW] = '0;
               mcnt[i][l] = 0;
            end
         end else if (sl && en[l]) begin
            mh[i][l]   = sv;
            mcnt[i][l] = PH;
         end
         e_lock[i][l] = (mcnt[i][l] == PH);
      end
   endtask

   // Compare both instances against the model after every clock edge.
   always @(posedge CLK) begin
      #1;
      if (chk_on) begin
         chk("scr_valid", TW'(s_vld), TW'(e_vld[0]));
         chk("scr_data",  s_data,     e_data[0]);
         chk("scr_lock",  TW'(s_lock), TW'(e_lock[0]));
         chk("dsc_valid", TW'(d_vld), TW'(e_vld[1]));
         chk("dsc_data",  d_data,     e_data[1]);
         chk("dsc_lock",  TW'(d_lock), TW'(e_lock[1]));
      end
   end

   // Drive one cycle at the falling edge. The descrambler's inputs for this
   // cycle are the scrambler's current outputs.
   task automatic drive(input logic v, input logic [TW-1:0] x, input logic [NL-1:0] en,
                        input logic sl, input logic [PH-1:0] sv);
      @(negedge CLK);
      in_valid   = v;
      in_data    = x;
      lane_en    = en;
      seed_load  = sl;
      seed_value = sv;
      model_step(1, e_vld[0], e_data[0], '1, 1'b0, '0);
      model_step(0, v, x, en, sl, sv);
   endtask

   task automatic settle();
      @(posedge CLK);
      #2;
   endtask

   function automatic logic [TW-1:0] cnt_word(input int w);
      logic [TW-1:0] r;
      logic [15:0]   c;
      r = '0;
      for (int l = 0; l < NL; l++) begin
         c = 16'(w * NL + l);
         r[l*DW +: DW] = {4{c}};
      end
      return r;
   endfunction

   logic [TW-1:0] words [16];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      in_valid   = 1'b0;
      in_data    = '0;
      lane_en    = '1;
      seed_load  = 1'b0;
      seed_value = '0;
      model_reset();
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #2;
      chk("rst_valid", TW'(s_vld), '0);
      chk("rst_data",  s_data,     '0);
      chk("rst_lock",  TW'(s_lock), '0);
      #9 reset_n = 1'b1;
      chk_on = 1'b1;

      // All-zero input after reset gives all-zero output.
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, '0, '1, 1'b0, '0);
         settle();
         chk("t1_data", s_data, '0);
         chk("t1_valid", TW'(s_vld), TW'(1'b1));
      end
      drive(1'b0, '0, '1, 1'b0, '0);
      settle();
      chk("t1_idle_valid", TW'(s_vld), '0);

      // A single 1 bit expands through both taps.
      drive(1'b1, TW'(1), '1, 1'b0, '0);
      settle();
      chk("t2_lane0", TW'(s_data[DW-1:0]), TW'(64'h0400_0080_0000_0001));
      chk("t2_lock0", TW'(s_lock[0]), TW'(1'b1));
      drive(1'b1, '0, '1, 1'b0, '0);
      settle();

      // Scrambler followed by descrambler returns the original data.
      for (int i = 0; i < 8; i++) begin
         words[i] = cnt_word(i);
         drive(1'b1, words[i], '1, 1'b0, '0);
         settle();
         if (i >= 2) chk("t3_roundtrip", d_data, words[i-1]);
         if (i >= 1) chk("t3_dsc_lock", TW'(d_lock), TW'(4'hF));
      end

      // Lane 2 disabled for three words.
      for (int i = 8; i < 14; i++) begin
         words[i] = cnt_word(i);
         drive(1'b1, words[i], (i >= 9 && i <= 11) ? 4'b1011 : 4'b1111, 1'b0, '0);
         settle();
         if (i >= 9 && i <= 11) begin
            chk("t4_lane2_zero", TW'(s_data[2*DW +: DW]), '0);
            chk("t4_lane2_lock", TW'(s_lock[2]), '0);
         end
         if (i == 12) chk("t4_lane2_relock", TW'(s_lock[2]), TW'(1'b1));
         for (int l = 0; l < NL; l++)
            if (l != 2) chk("t4_other_lanes", TW'(d_data[l*DW +: DW]), TW'(words[i-1][l*DW +: DW]));
      end

      // Seed loaded together with a zero word.
      drive(1'b1, '0, '1, 1'b1, 58'h3FF_FFFF_FFFF_FFFF);
      settle();
      chk("t5_lane0", TW'(s_data[DW-1:0]), TW'(64'h03FF_FF80_0000_0000));
      chk("t5_lane3", TW'(s_data[3*DW +: DW]), TW'(64'h03FF_FF80_0000_0000));
      chk("t5_lock", TW'(s_lock), TW'(4'hF));
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, '0, '1, 1'b0, '0);
         settle();
      end

      // Short asynchronous reset pulse mid-stream.
      drive(1'b0, '0, '1, 1'b0, '0);
      #1 reset_n = 1'b0;
      #1;
      chk("t6_async_valid", TW'(s_vld), '0);
      chk("t6_async_data",  s_data,     '0);
      chk("t6_async_lock",  TW'(s_lock), '0);
      chk("t6_async_dsc",   d_data,     '0);
      #2 reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, '0, '1, 1'b0, '0);
         settle();
         chk("t6_data", s_data, '0);
         chk("t6_lock", TW'(s_lock), TW'(4'hF));
      end

      drive(1'b0, '0, '1, 1'b0, '0);
      settle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
